mem_request_arbiter: RTL

- Shares the single SRAM command port of the memory backend between four request FIFOs: bucket write, bucket read, texture write and texture read.
- Sits between the bucket/texture request FIFOs and the memory controller backend.
- Tags every issued read and routes each read response back into the correct read-data FIFO, in order.
- Counts credits so a read is never issued unless its destination read FIFO is guaranteed to have space.

---
 rtl/mem_request_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: round-robin sharing of the SRAM command port between bucket/texture write and read FIFOs,
// with read tagging, in-order response routing and read-FIFO credits. Define TEXTURE_PRIORITY_EN for strict texture-read priority.
module mem_request_arbiter #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int RD_CREDITS = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic clk100,
  input  logic rst_n,
  input  logic [ADDR_W+DATA_W-1:0] bw_data,
  input  logic bw_empty,
  output logic bw_pop,
  input  logic [ADDR_W-1:0] br_data,
  input  logic br_empty,
  output logic br_pop,
  input  logic [ADDR_W+DATA_W-1:0] tw_data,
  input  logic tw_empty,
  output logic tw_pop,
  input  logic [ADDR_W-1:0] tr_data,
  input  logic tr_empty,
  output logic tr_pop,
  input  logic br_rdfifo_pop,
  input  logic tr_rdfifo_pop,
  output logic cmd_valid,
  input  logic cmd_ready,
  output logic cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] br_rd_data,
  output logic br_rd_push,
  output logic [DATA_W-1:0] tr_rd_data,
  output logic tr_rd_push,
  output logic rsp_err
);
  localparam int CW = $clog2(RD_CREDITS + 1);
  localparam int PW = $clog2(MAX_OUTST);
  logic [CW-1:0] brCredit, trCredit;
  logic [1:0] rrPtr, rrGrant, grant;
  logic [3:0] elig, rrElig;
  logic found, load, advance, tagFull, tagEmpty, tagPush, tagPop;
  logic tagMem [MAX_OUTST];
  logic [PW-1:0] tagWr, tagRd;
  logic [PW:0] tagCnt;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData, rdData;
  assign tagFull = tagCnt == (PW+1)'(MAX_OUTST);
  assign tagEmpty = tagCnt == '0;
  assign elig = {!tr_empty && trCredit != '0 && !tagFull, !tw_empty,
                 !br_empty && brCredit != '0 && !tagFull, !bw_empty};
`ifdef TEXTURE_PRIORITY_EN
  // Texture reads bypass the rotation and leave the pointer untouched.
  assign rrElig = {1'b0, elig[2:0]};
  assign grant = elig[3] ? 2'd3 : rrGrant;
  assign advance = !elig[3];
`else
  assign rrElig = elig;
  assign grant = rrGrant;
  assign advance = 1'b1;
`endif
  always_comb begin
    rrGrant = rrPtr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && rrElig[rrPtr + 2'(i)]) begin
        rrGrant = rrPtr + 2'(i);
        found = 1'b1;
      end
    end
  end
  // Pops are combinational: the FWFT head is consumed on the same edge that loads the command.
  assign load = rst_n && (!cmd_valid || cmd_ready) && |elig;
  assign bw_pop = load && grant == 2'd0;
  assign br_pop = load && grant == 2'd1;
  assign tw_pop = load && grant == 2'd2;
  assign tr_pop = load && grant == 2'd3;
  assign selAddr = grant == 2'd0 ? bw_data[ADDR_W-1:0] : grant == 2'd1 ? br_data :
                   grant == 2'd2 ? tw_data[ADDR_W-1:0] : tr_data;
  assign selData = grant == 2'd0 ? bw_data[ADDR_W +: DATA_W] : grant == 2'd2 ? tw_data[ADDR_W +: DATA_W] : '0;
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      rrPtr <= '0;
    end else if (load) begin
      cmd_valid <= 1'b1;
      cmd_write <= !grant[0];
      cmd_addr <= selAddr;
      cmd_wdata <= selData;
      if (advance) rrPtr <= grant + 2'd1;
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      brCredit <= CW'(RD_CREDITS);
      trCredit <= CW'(RD_CREDITS);
    end else begin
      if (br_pop && !br_rdfifo_pop) brCredit <= brCredit - CW'(1);
      else if (!br_pop && br_rdfifo_pop && brCredit != CW'(RD_CREDITS)) brCredit <= brCredit + CW'(1);
      if (tr_pop && !tr_rdfifo_pop) trCredit <= trCredit - CW'(1);
      else if (!tr_pop && tr_rdfifo_pop && trCredit != CW'(RD_CREDITS)) trCredit <= trCredit + CW'(1);
    end
  end
  // Tag queue: 0 = bucket, 1 = texture; responses drain it in issue order.
  assign tagPush = br_pop || tr_pop;
  assign tagPop = rsp_valid && !tagEmpty;
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      tagWr <= '0;
      tagRd <= '0;
      tagCnt <= '0;
    end else begin
      if (tagPush) tagWr <= tagWr + PW'(1);
      if (tagPop) tagRd <= tagRd + PW'(1);
      tagCnt <= tagCnt + (PW+1)'(tagPush) - (PW+1)'(tagPop);
    end
  end
  always_ff @(posedge clk100) begin
    if (tagPush) tagMem[tagWr] <= tr_pop;
  end
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      br_rd_push <= 1'b0;
      tr_rd_push <= 1'b0;
      rdData <= '0;
      rsp_err <= 1'b0;
    end else begin
      br_rd_push <= tagPop && !tagMem[tagRd];
      tr_rd_push <= tagPop && tagMem[tagRd];
      if (rsp_valid) rdData <= rsp_data;
      if (rsp_valid && tagEmpty) rsp_err <= 1'b1;
    end
  end
  assign br_rd_data = rdData;
  assign tr_rd_data = rdData;
endmodule
